// File: rtl/editor_hora_user.sv
// User time/date editor: seeds from the stored word, steps through six BCD fields
// with wrap-around increment/decrement, commits with a one-cycle write strobe.
module editor_hora_user #(
  parameter int unsigned TIMEOUT_CYCLES = 500000000,
  parameter int unsigned TO_W           = 29
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        btn_edit,
  input  logic        btn_next,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [47:0] dato_actual,
  output logic [47:0] dato_user,
  output logic        estado,
  output logic [2:0]  campo,
  output logic        write_pulse
);

  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

  state_t            state, next_state;
  logic [TO_W-1:0]   cnt;
  logic [47:0]       edited_word;
  logic              any_btn;
  logic              timed_out;

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [7:0] fmin(input int unsigned i);
    return (i == 3 || i == 4) ? 8'h01 : 8'h00;
  endfunction

  function automatic logic [7:0] fmax(input int unsigned i);
    case (i)
      0:       return 8'h23;
      1, 2:    return 8'h59;
      3:       return 8'h31;
      4:       return 8'h12;
      default: return 8'h99;
    endcase
  endfunction

  // Byte-wise compare is valid for BCD ordering once both nibbles are <= 9.
  function automatic logic valid_field(input logic [7:0] v, input int unsigned i);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= fmin(i)) && (v <= fmax(i));
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input int unsigned i);
    if (!valid_field(v, i) || v == fmax(i)) return fmin(i);
    else if (v[3:0] == 4'd9)                return {v[7:4] + 4'd1, 4'd0};
    else                                     return v + 8'd1;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input int unsigned i);
    if (!valid_field(v, i) || v == fmin(i)) return fmax(i);
    else if (v[3:0] == 4'd0)                return {v[7:4] - 4'd1, 4'd9};
    else                                     return v - 8'd1;
  endfunction

  assign any_btn   = btn_edit | btn_next | btn_up | btn_down;
  assign timed_out = !any_btn && (cnt == LIMIT);

  // Field 0 (hours) occupies the top byte, so field i lives at byte 5-i.
  always_comb begin
    edited_word = dato_user;
    for (int unsigned i = 0; i < 6; i++) begin
      if (campo == 3'(i)) begin
        edited_word[(5-i)*8 +: 8] = btn_up ? bcd_inc(dato_user[(5-i)*8 +: 8], i)
                                           : bcd_dec(dato_user[(5-i)*8 +: 8], i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      dato_user <= '0;
      campo     <= '0;
      cnt       <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (btn_edit) begin
            dato_user <= dato_actual;
            campo     <= '0;
            cnt       <= '0;
          end
        end
        EDIT: begin
          cnt <= any_btn ? '0 : cnt + 1'b1;
          if (!btn_edit) begin
            if (btn_next)                campo     <= (campo == 3'd5) ? 3'd0 : campo + 3'd1;
            else if (btn_up || btn_down) dato_user <= edited_word;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (btn_edit) next_state = EDIT;
      EDIT: begin
        if (btn_edit)       next_state = COMMIT;
        else if (timed_out) next_state = IDLE;
      end
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    estado      = (state != IDLE);
    write_pulse = (state == COMMIT);
  end

endmodule
